// File: rtl/decoder_3x8_buffered.sv
// Buffered 3:8 decoder: valid/ready code input, one-hot output through a 2-entry skid FIFO.
// Optional DEC_STATS_EN adds a saturating count of in_vld=0 transfers on stat_zero.
//
// state    | meaning
// ST_EMPTY | no entries held, out_valid=0, out_onehot=0
// ST_ONE   | head entry valid, tail free
// ST_FULL  | head and tail valid, in_ready=0
module decoder_3x8_buffered #(
    parameter int CODE_W = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [CODE_W-1:0]      in_code,
    input  logic                   in_vld,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [2**CODE_W-1:0]   out_onehot,
    input  logic                   out_ready
`ifdef DEC_STATS_EN
    ,
    output logic [7:0]             stat_zero
`endif
);

    localparam int OUT_W = 2**CODE_W;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [OUT_W-1:0] head_q, head_d;
    logic [OUT_W-1:0] tail_q, tail_d;
    logic [OUT_W-1:0] dec_code;
    logic             push;
    logic             pop;

    // Handshake flags come from registered state only, so out_ready never reaches in_ready.
    assign in_ready   = (state_q != ST_FULL);
    assign out_valid  = (state_q != ST_EMPTY);
    assign out_onehot = out_valid ? head_q : '0;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_comb begin
        dec_code = '0;
        if (in_vld) begin
            dec_code[in_code] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    head_d  = dec_code;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (push && !pop) begin
                    tail_d  = dec_code;
                    state_d = ST_FULL;
                end else if (pop && !push) begin
                    head_d  = '0;
                    state_d = ST_EMPTY;
                end else if (push && pop) begin
                    head_d  = dec_code;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    head_d  = tail_q;
                    tail_d  = '0;
                    state_d = ST_ONE;
                end
            end
            default: begin
                head_d  = '0;
                tail_d  = '0;
                state_d = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

`ifdef DEC_STATS_EN
    logic [7:0] stat_zero_q, stat_zero_d;

    always_comb begin
        stat_zero_d = stat_zero_q;
        if (push && !in_vld && (stat_zero_q != 8'hFF)) begin
            stat_zero_d = stat_zero_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_zero_q <= 8'd0;
        end else begin
            stat_zero_q <= stat_zero_d;
        end
    end

    assign stat_zero = stat_zero_q;
`endif

endmodule

// File: tb/tb_decoder_3x8_buffered.sv
// Scoreboard bench for decoder_3x8_buffered: directed scenarios then randomized traffic.
// Build with DEC_STATS_EN defined to also check the zero-transfer counter.
module tb_decoder_3x8_buffered;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [2:0] in_code;
    logic       in_vld;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_onehot;
    logic       out_ready;
`ifdef DEC_STATS_EN
    logic [7:0] stat_zero;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    int         occ       = 0;
    int         pop_cnt   = 0;
    int         zero_cnt  = 0;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_val  = 8'h00;

    decoder_3x8_buffered dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_code    (in_code),
        .in_vld     (in_vld),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_onehot (out_onehot),
        .out_ready  (out_ready)
`ifdef DEC_STATS_EN
        ,
        .stat_zero  (stat_zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] model_decode(input int code, input bit vld);
        int v;
        v = vld ? (2 ** code) : 0;
        return 8'(v);
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Expectation recorder: every accepted code becomes an expected one-hot value.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            exp_q.push_back(model_decode(int'(in_code), in_vld));
            if (!in_vld && zero_cnt < 255) zero_cnt++;
        end
    end

    // Monitor: compares outputs against the scoreboard and the occupancy model.
    always @(negedge clk) begin
        int nxt;
        if (rst_n) begin
            check("out_valid_vs_occ", int'(out_valid), int'(occ > 0));
            check("in_ready_vs_occ", int'(in_ready), int'(occ < 2));
            if (!out_valid) check("empty_onehot_zero", int'(out_onehot), 0);
            if (prev_hold) check("hold_stable", int'(out_onehot), int'(prev_val));
            nxt = occ;
            if (in_valid && in_ready) nxt++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_underflow: got 0x%0h, expected no output", out_onehot);
                end else begin
                    check("onehot_data", int'(out_onehot), int'(exp_q.pop_front()));
                end
                pop_cnt++;
                nxt--;
            end
            occ       = nxt;
            prev_hold = out_valid && !out_ready;
            prev_val  = out_onehot;
        end else begin
            prev_hold = 1'b0;
        end
    end

    task automatic drive(input bit v, input int code, input bit vld, input bit ordy);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_code   = 3'(code);
        in_vld    = vld;
        out_ready = ordy;
    endtask

    task automatic apply_reset();
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_onehot", int'(out_onehot), 0);
        exp_q.delete();
        occ       = 0;
        zero_cnt  = 0;
        prev_hold = 1'b0;
`ifdef DEC_STATS_EN
        check("rst_stat_zero", int'(stat_zero), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int p0;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_code   = 3'd0;
        in_vld    = 1'b0;
        out_ready = 1'b0;
        apply_reset();

        // Single push of code 5
        drive(1, 5, 1, 1);
        drive(0, 0, 0, 1);
        #2 check("single_valid", int'(out_valid), 1);
        check("single_onehot", int'(out_onehot), 8'h20);
        drive(0, 0, 0, 1);
        #2 check("single_drained", int'(out_valid), 0);

        // Fill to FULL with out_ready low, then drain in order
        drive(1, 0, 1, 0);
        drive(1, 7, 1, 0);
        drive(0, 0, 0, 0);
        #2 check("full_in_ready", int'(in_ready), 0);
        check("full_head", int'(out_onehot), 8'h01);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 1);
        #2 check("full_second", int'(out_onehot), 8'h80);
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 0);

        // vld=0 transfer is a real, all-zero entry
        drive(1, 6, 0, 0);
        drive(0, 0, 0, 0);
        #2 check("zero_entry_valid", int'(out_valid), 1);
        check("zero_entry_onehot", int'(out_onehot), 0);
`ifdef DEC_STATS_EN
        check("stat_zero_one", int'(stat_zero), 1);
`endif
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 1);

        // Streaming 0..7 back-to-back: one pop per cycle once primed
        p0 = pop_cnt;
        for (int i = 0; i < 8; i++) drive(1, i, 1, 1);
        drive(0, 0, 0, 1);
        #2 check("stream_pops", pop_cnt - p0, 7);
        drive(0, 0, 0, 1);
        #2 check("stream_all_out", pop_cnt - p0, 8);

        // Reset while FULL
        drive(1, 2, 1, 0);
        drive(1, 4, 1, 0);
        drive(0, 0, 0, 0);
        #2 check("pre_reset_full", int'(in_ready), 0);
        apply_reset();
        drive(1, 3, 1, 1);
        drive(0, 0, 0, 1);
        #2 check("post_reset_push", int'(out_onehot), 8'h08);
        drive(0, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 99) < 65), $urandom_range(0, 7),
                  ($urandom_range(0, 99) < 75), ($urandom_range(0, 99) < 55));
        end
        for (int i = 0; i < 6; i++) drive(0, 0, 0, 1);
        #2 check("drained_queue", exp_q.size(), 0);
`ifdef DEC_STATS_EN
        check("stat_zero_final", int'(stat_zero), zero_cnt);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
